// File: rtl/output_writeback_ctrl.sv
// output_writeback_ctrl
//   Packs 16-lane PE output vectors into SRAM words, buffers them in a
//   2-entry FIFO and writes them through the shared SRAM write port at
//   consecutive addresses starting from a latched base address.
// Ports:
//   clk, rst_n_in                   clock, synchronous active-low reset
//   start, base_addr, num_words     tile setup (start is honoured in IDLE only)
//   outputs_in/_valid/_ready        vector input handshake
//   mem_req, mem_gnt, mem_we        write-port request/grant; write = req && gnt
//   mem_addr, mem_wdata             write address and FIFO head data
//   busy, done                      tile in progress / one-cycle completion pulse
module output_writeback_ctrl #(
    parameter int IO_DATA_WIDTH = 8,
    parameter int MEM_BW        = 128,
    parameter int ADDR_WIDTH    = 11,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n_in,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [CNT_WIDTH-1:0]       num_words,
    input  logic [16*IO_DATA_WIDTH-1:0] outputs_in,
    input  logic                       outputs_valid,
    output logic                       outputs_ready,
    output logic                       mem_req,
    input  logic                       mem_gnt,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [MEM_BW-1:0]          mem_wdata,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [CNT_WIDTH-1:0]      num_q, num_d;
    logic [CNT_WIDTH-1:0]      accept_cnt_q, accept_cnt_d;
    logic [CNT_WIDTH-1:0]      write_cnt_q, write_cnt_d;
    logic [1:0][MEM_BW-1:0]    fifo_q, fifo_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [MEM_BW-1:0]         packed_word;
    logic                      push, pop;

    // Lane k lands at bits [k*W +: W]; lane 15 ends up in the MSBs.
    always_comb begin
        packed_word = '0;
        for (int k = 0; k < 16; k++) begin
            packed_word[k*IO_DATA_WIDTH +: IO_DATA_WIDTH] = outputs_in[k*IO_DATA_WIDTH +: IO_DATA_WIDTH];
        end
    end

    assign mem_req       = (count_q != 2'd0);
    assign mem_we        = mem_req && mem_gnt;
    assign mem_addr      = base_q + write_cnt_q[ADDR_WIDTH-1:0];
    assign mem_wdata     = fifo_q[rd_ptr_q];
    assign outputs_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // ready_q is registered, so accepting never depends on this cycle's grant.
    assign push = outputs_valid && ready_q;
    assign pop  = mem_we;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        accept_cnt_d = accept_cnt_q;
        write_cnt_d  = write_cnt_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            fifo_d[wr_ptr_q] = packed_word;
            wr_ptr_d         = ~wr_ptr_q;
            accept_cnt_d     = accept_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d    = ~rd_ptr_q;
            write_cnt_d = write_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d       = base_addr;
                    num_d        = num_words;
                    accept_cnt_d = '0;
                    write_cnt_d  = '0;
                    state_d      = (num_words != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept_cnt_d == num_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Look at post-write values so done follows the last write directly.
                if (count_d == 2'd0 && write_cnt_d == num_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == RUN) && (count_d != 2'd2) && (accept_cnt_d < num_d);
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            base_q       <= '0;
            num_q        <= '0;
            accept_cnt_q <= '0;
            write_cnt_q  <= '0;
            fifo_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            accept_cnt_q <= accept_cnt_d;
            write_cnt_q  <= write_cnt_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_output_writeback_ctrl.sv
// Directed bench for output_writeback_ctrl: a negedge monitor logs every
// write and done pulse; the initial block drives tiles and compares the log
// against vectors generated from a per-tile seed.
module tb_output_writeback_ctrl;

    logic         clk = 1'b0;
    logic         rst_n_in;
    logic         start;
    logic [10:0]  base_addr;
    logic [15:0]  num_words;
    logic [127:0] outputs_in;
    logic         outputs_valid;
    logic         outputs_ready;
    logic         mem_req;
    logic         mem_gnt;
    logic         mem_we;
    logic [10:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         busy;
    logic         done;

    output_writeback_ctrl dut (
        .clk(clk), .rst_n_in(rst_n_in), .start(start), .base_addr(base_addr),
        .num_words(num_words), .outputs_in(outputs_in), .outputs_valid(outputs_valid),
        .outputs_ready(outputs_ready), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]  addr;
        logic [127:0] data;
        int           cyc;
    } wr_t;

    wr_t  log_q[$];
    int   cyc_cnt  = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   req_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;
    int   sent     = 0;
    int   start_cyc = 0;
    logic [7:0] cur_seed = 8'h00;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_we) log_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc_cnt + 1});
        if (mem_req) req_cnt <= req_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_cnt + 1;
        end
    end

    function automatic logic [127:0] vec(input logic [7:0] s);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = s + 8'(k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs applied 2 time units after the edge, then the
    // handshake for this cycle is resolved 1 unit later.
    task automatic step(input bit v, input bit g, input bit s, input bit r);
        @(posedge clk); #2;
        start         = s;
        rst_n_in      = r;
        outputs_valid = v;
        mem_gnt       = g;
        outputs_in    = vec(cur_seed + 8'(sent));
        #1;
        if (outputs_valid && outputs_ready) sent++;
    endtask

    task automatic do_start(input logic [10:0] b, input logic [15:0] n, input logic [7:0] seed);
        log_q.delete();
        done_cnt  = 0;
        req_cnt   = 0;
        cur_seed  = seed;
        sent      = 0;
        base_addr = b;
        num_words = n;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        start_cyc = cyc_cnt + 1;
    endtask

    task automatic finish_tile(input string tag, input int budget, input int vpct, input int gpct);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            step(32'($urandom_range(99)) < vpct, 32'($urandom_range(99)) < gpct, 1'b0, 1'b1);
            i++;
        end
        chk({tag, "_no_timeout"}, 128'(i < budget), 128'(1));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_log(input string tag, input logic [10:0] b, input int n);
        logic [10:0] ea;
        chk({tag, "_count"}, 128'(log_q.size()), 128'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            ea = b + 11'(i);
            chk($sformatf("%s_addr%0d", tag, i), 128'(log_q[i].addr), 128'(ea));
            chk($sformatf("%s_data%0d", tag, i), log_q[i].data, vec(cur_seed + 8'(i)));
        end
        chk({tag, "_done_once"}, 128'(done_cnt), 128'(1));
    endtask

    initial begin
        rst_n_in = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        outputs_in = '0; outputs_valid = 1'b0; mem_gnt = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_ready", 128'(outputs_ready), 128'(0));
        chk("reset_req",   128'(mem_req), 128'(0));
        chk("reset_addr",  128'(mem_addr), 128'(0));
        chk("reset_wdata", mem_wdata, 128'(0));
        chk("reset_busy_done", 128'({busy, done}), 128'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Streaming tile, full throughput.
        do_start(11'h010, 16'd4, 8'h10);
        finish_tile("t1", 100, 100, 100);
        check_log("t1", 11'h010, 4);
        if (log_q.size() == 4) begin
            chk("t1_lane0",  128'(log_q[0].data[7:0]), 128'(8'h10));
            chk("t1_lane15", 128'(log_q[0].data[127:120]), 128'(8'h1F));
            chk("t1_first_latency", 128'(log_q[0].cyc - start_cyc), 128'(2));
            chk("t1_consecutive", 128'(log_q[3].cyc - log_q[0].cyc), 128'(3));
            chk("t1_done_after_last", 128'(done_cyc - log_q[3].cyc), 128'(1));
        end

        // Backpressure: no grant for 5 cycles while 3 vectors are offered.
        do_start(11'h100, 16'd3, 8'h40);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_ready_c1", 128'(outputs_ready), 128'(1));
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_ready_c2", 128'(outputs_ready), 128'(1));
        chk("t2_req_c2", 128'(mem_req), 128'(1));
        for (int c = 3; c <= 5; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            chk($sformatf("t2_ready_c%0d", c), 128'(outputs_ready), 128'(0));
            chk($sformatf("t2_addr_c%0d", c), 128'(mem_addr), 128'(11'h100));
            chk($sformatf("t2_wdata_c%0d", c), mem_wdata, vec(8'h40));
            chk($sformatf("t2_busy_c%0d", c), 128'(busy), 128'(1));
        end
        chk("t2_accepted", 128'(sent), 128'(2));
        finish_tile("t2", 100, 100, 100);
        check_log("t2", 11'h100, 3);

        // Empty tile: no requests, single done shortly after start.
        do_start(11'h050, 16'd0, 8'h20);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_no_req", 128'(req_cnt), 128'(0));
        chk("t3_done_once", 128'(done_cnt), 128'(1));
        chk("t3_done_soon", 128'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 128'(1));

        // Address wrap.
        do_start(11'h7FE, 16'd4, 8'h30);
        finish_tile("t4", 100, 100, 100);
        check_log("t4", 11'h7FE, 4);
        if (log_q.size() == 4) chk("t4_wrap_addr", 128'(log_q[2].addr), 128'(11'h000));

        // Second start while busy is ignored; reset after two writes aborts.
        do_start(11'h200, 16'd6, 8'h60);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        base_addr = 11'h300; num_words = 16'd2;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_busy", 128'(busy), 128'(1));
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_addr_ignores_start", 128'(mem_addr), 128'(11'h201));
        rst_n_in = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_reset_outputs",
            128'({outputs_ready, mem_req, mem_we, busy, done, mem_addr}), 128'(0));
        chk("t5_reset_wdata", mem_wdata, 128'(0));
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_no_done", 128'(done_cnt), 128'(0));
        chk("t5_two_writes", 128'(log_q.size()), 128'(2));
        do_start(11'h400, 16'd3, 8'h80);
        finish_tile("t5b", 100, 100, 100);
        check_log("t5b", 11'h400, 3);

        // Random valid/grant, long tile.
        do_start(11'h123, 16'd200, 8'h05);
        finish_tile("t6", 3000, 50, 50);
        check_log("t6", 11'h123, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
